hdlc_rx_ctrl: RTL and testbench
===============================

Name: hdlc_rx_ctrl

Overview:
Frame-level sequencer for the HDLC receive path. It consumes flag, abort and byte-complete events from the Rx bit datapath, which handles flag detection and zero removal. It generates buffer write strobes, end-of-frame and the Rx status bits (Ready, Overflow, AbortSignal, FrameError, FrameSize) presented in the Rx status/control register. It holds a completed frame until software reads it or drops it.

Parameters:
MAX_BYTES  128  max bytes stored per frame, FCS bytes included
MIN_BYTES  3    min bytes for a legal frame when FCS is enabled (1 data + 2 FCS)
SIZE_W     8    width of byte counter and Rx_FrameSize

Ports:
Clk             in   1       system clock
Rst             in   1       synchronous reset, active-low
Rx_FlagDetect   in   1       1-cycle pulse, flag 01111110 received
Rx_AbortDetect  in   1       1-cycle pulse, 7+ consecutive ones received
Rx_NewByte      in   1       1-cycle pulse, de-stuffed byte complete
Rx_ByteAligned  in   1       level, 1 = no residual bits since last byte
Rx_FCSen        in   1       level, config: FCS check enabled
Rx_FCSerr       in   1       level, FCS checker result; valid in the Rx_FlagDetect cycle
Rx_ReadDone     in   1       1-cycle pulse, buffer fully read by host
Rx_Drop         in   1       1-cycle pulse, host discards current frame
Rx_ValidFrame   out  1       frame in progress
Rx_WrBuff       out  1       1-cycle buffer write strobe
Rx_EoF          out  1       1-cycle end-of-frame pulse
Rx_AbortSignal  out  1       sticky, frame aborted
Rx_Overflow     out  1       sticky, frame exceeded MAX_BYTES
Rx_FrameError   out  1       sticky, short, misaligned or FCS-failed frame
Rx_Ready        out  1       good frame available in buffer
Rx_FrameSize    out  SIZE_W  payload byte count of the ready frame

Behaviour:
- Reset: Rst=0 at a posedge sets all outputs to 0, the state to IDLE and the byte count to 0. Reset overrides every other event, including mid-frame.
- All outputs are registered and change one cycle after the causing input.
- States: IDLE, FRAME, HOLD.
- IDLE -> FRAME on Rx_FlagDetect.
  - Entering FRAME clears AbortSignal, Overflow, FrameError and sets count=0.
- FRAME: Rx_ValidFrame=1.
- Byte handling in FRAME, on Rx_NewByte:
  - count<MAX_BYTES: Rx_WrBuff=1 next cycle, count++.
  - count==MAX_BYTES: no write; the frame is marked overflowed.
- FRAME + Rx_FlagDetect with count==0: remains in FRAME. This covers idle and shared flags; no EoF.
- FRAME + Rx_FlagDetect with count>0: closing flag.
  - Next cycle: Rx_EoF=1, Rx_ValidFrame=0, and all status bits update in that same cycle.
  - Priority: overflow > frame error > good.
  - Frame error if any of: !Rx_ByteAligned; Rx_FCSen && (count<MIN_BYTES || Rx_FCSerr); !Rx_FCSen && count==0.
  - Good frame: Rx_Ready=1, Rx_FrameSize = count-2 if Rx_FCSen else count. Go to HOLD.
  - Bad frame: Ready stays 0; the status bit is held. The closing flag is also the opening flag, so state stays FRAME with count=0; status bits are not cleared in this case.
- FRAME + Rx_AbortDetect:
  - Next cycle: Rx_AbortSignal=1, Rx_EoF=1, Rx_ValidFrame=0. Overflow, FrameError and Ready stay 0. Go to IDLE.
  - Abort has priority over a same-cycle Rx_NewByte or Rx_FlagDetect.
- Rx_AbortDetect outside FRAME is ignored.
- Status at the Rx_EoF cycle is exactly one of: {AbortSignal}, {Overflow}, {FrameError}, {Ready}.
- HOLD: all Rx events are ignored; no WrBuff or EoF.
  - Rx_ReadDone or Rx_Drop: next cycle Rx_Ready=0, Rx_FrameSize=0, go to IDLE.
- Rx_Drop in FRAME: discard the frame. Count=0, Rx_ValidFrame=0, go to IDLE, no EoF.
- Rx_Drop in IDLE clears the sticky status bits.
- Rx_ReadDone outside HOLD is ignored.
- Simultaneous Rx_NewByte and closing Rx_FlagDetect: the byte is counted before the end-of-frame evaluation.

Decomposition:
- hdlc_pkg:
  - typedef enum rx_ctrl_state_t {IDLE, FRAME, HOLD}
  - constants HDLC_FCS_BYTES=2, HDLC_MAX_BYTES=128
- Sub-module hdlc_rx_bytecnt: saturating counter with clear, inc and at_max outputs.
- Remainder is a single FSM with a status register.

Test Plan:
1. Flag, 5 bytes, flag (FCSen=1, FCSerr=0, aligned=1) -> 5 WrBuff pulses; 1 EoF; Ready=1, FrameSize=3, other status bits 0 at the EoF cycle.
2. Flag, 3 bytes, AbortDetect -> AbortSignal=1 and EoF=1 exactly 1 cycle after AbortDetect; Ready=0; state IDLE; next flag clears AbortSignal.
3. Flag, 130 bytes, flag -> exactly 128 WrBuff pulses; at EoF Overflow=1, Ready=0, FrameError=0.
4. Flag, 2 bytes, flag (FCSen=1) -> FrameError=1. Repeat with 4 bytes and FCSerr=1 -> FrameError=1. Repeat with aligned=0 -> FrameError=1.
5. Good frame -> HOLD; a second frame while in HOLD -> no WrBuff, Ready stays 1; ReadDone -> Ready=0, FrameSize=0 next cycle.
6. Rst=0 asserted while in FRAME after 10 bytes -> next cycle all outputs 0, state IDLE; the following clean frame completes normally.

Source files
------------

// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared types and constants for the HDLC receive path
package hdlc_pkg;

  typedef enum logic [1:0] {IDLE, FRAME, HOLD} rx_ctrl_state_t;

  localparam int HDLC_FCS_BYTES = 2;
  localparam int HDLC_MAX_BYTES = 128;

endpackage

// File: rtl/hdlc_rx_ctrl_if.sv
// rtl/hdlc_rx_ctrl_if.sv - event/status bundle between Rx datapath, host and the Rx frame sequencer
interface hdlc_rx_ctrl_if #(parameter int SIZE_W = 8);

  logic              Rx_FlagDetect;
  logic              Rx_AbortDetect;
  logic              Rx_NewByte;
  logic              Rx_ByteAligned;
  logic              Rx_FCSen;
  logic              Rx_FCSerr;
  logic              Rx_ReadDone;
  logic              Rx_Drop;
  logic              Rx_ValidFrame;
  logic              Rx_WrBuff;
  logic              Rx_EoF;
  logic              Rx_AbortSignal;
  logic              Rx_Overflow;
  logic              Rx_FrameError;
  logic              Rx_Ready;
  logic [SIZE_W-1:0] Rx_FrameSize;

  modport master (
    output Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_ByteAligned, Rx_FCSen, Rx_FCSerr,
           Rx_ReadDone, Rx_Drop,
    input  Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Overflow, Rx_FrameError,
           Rx_Ready, Rx_FrameSize
  );

  modport slave (
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_ByteAligned, Rx_FCSen, Rx_FCSerr,
           Rx_ReadDone, Rx_Drop,
    output Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_Overflow, Rx_FrameError,
           Rx_Ready, Rx_FrameSize
  );

endinterface

// File: rtl/hdlc_rx_bytecnt.sv
// rtl/hdlc_rx_bytecnt.sv - saturating per-frame byte counter with clear priority over increment
module hdlc_rx_bytecnt
  import hdlc_pkg::*;
#(
  parameter int MAX = HDLC_MAX_BYTES,
  parameter int W   = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Count,
  output logic         AtMax
);

  assign AtMax = (Count == W'(MAX));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc && !AtMax) begin
      Count <= Count + 1'b1;
    end
  end

endmodule

// File: rtl/hdlc_rx_ctrl.sv
// rtl/hdlc_rx_ctrl.sv - HDLC Rx frame sequencer: buffer write strobes, end-of-frame and Rx status
module hdlc_rx_ctrl
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = HDLC_MAX_BYTES,
  parameter int MIN_BYTES = 3,
  parameter int SIZE_W    = 8
) (
  input logic           Clk,
  input logic           Rst,
  hdlc_rx_ctrl_if.slave rx
);

  rx_ctrl_state_t    state;
  logic [SIZE_W-1:0] count;
  logic [SIZE_W-1:0] effCount;
  logic              atMax;
  logic              ovfSeen;
  logic              inFrame, abortEv, dropEv, byteEv, wrEv, byteOvf, closeEv;
  logic              isOvf, isErr, cntClr;

  // Abort beats drop, drop beats byte/flag; a byte arriving with the closing flag is counted first.
  assign inFrame  = (state == FRAME);
  assign abortEv  = inFrame && rx.Rx_AbortDetect;
  assign dropEv   = inFrame && rx.Rx_Drop && !abortEv;
  assign byteEv   = inFrame && rx.Rx_NewByte && !abortEv && !dropEv;
  assign wrEv     = byteEv && !atMax;
  assign byteOvf  = byteEv && atMax;
  assign effCount = count + SIZE_W'(wrEv);
  assign closeEv  = inFrame && rx.Rx_FlagDetect && !abortEv && !dropEv && (effCount != '0);
  assign isOvf    = ovfSeen || byteOvf;
  assign isErr    = !rx.Rx_ByteAligned
                 || (rx.Rx_FCSen && ((effCount < SIZE_W'(MIN_BYTES)) || rx.Rx_FCSerr))
                 || (!rx.Rx_FCSen && (effCount == '0));
  assign cntClr   = abortEv || dropEv || closeEv || ((state == IDLE) && rx.Rx_FlagDetect);

  hdlc_rx_bytecnt #(.MAX(MAX_BYTES), .W(SIZE_W)) u_bytecnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (cntClr),
    .Inc  (wrEv),
    .Count(count),
    .AtMax(atMax)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state             <= IDLE;
      ovfSeen           <= 1'b0;
      rx.Rx_ValidFrame  <= 1'b0;
      rx.Rx_WrBuff      <= 1'b0;
      rx.Rx_EoF         <= 1'b0;
      rx.Rx_AbortSignal <= 1'b0;
      rx.Rx_Overflow    <= 1'b0;
      rx.Rx_FrameError  <= 1'b0;
      rx.Rx_Ready       <= 1'b0;
      rx.Rx_FrameSize   <= '0;
    end else begin
      rx.Rx_WrBuff <= wrEv;
      rx.Rx_EoF    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.Rx_FlagDetect) begin
            state             <= FRAME;
            ovfSeen           <= 1'b0;
            rx.Rx_ValidFrame  <= 1'b1;
            rx.Rx_AbortSignal <= 1'b0;
            rx.Rx_Overflow    <= 1'b0;
            rx.Rx_FrameError  <= 1'b0;
          end else if (rx.Rx_Drop) begin
            rx.Rx_AbortSignal <= 1'b0;
            rx.Rx_Overflow    <= 1'b0;
            rx.Rx_FrameError  <= 1'b0;
          end
        end
        FRAME: begin
          if (abortEv) begin
            state             <= IDLE;
            ovfSeen           <= 1'b0;
            rx.Rx_ValidFrame  <= 1'b0;
            rx.Rx_EoF         <= 1'b1;
            rx.Rx_AbortSignal <= 1'b1;
            rx.Rx_Overflow    <= 1'b0;
            rx.Rx_FrameError  <= 1'b0;
          end else if (dropEv) begin
            state            <= IDLE;
            ovfSeen          <= 1'b0;
            rx.Rx_ValidFrame <= 1'b0;
          end else if (closeEv) begin
            // A bad frame's closing flag also opens the next one, so state stays FRAME.
            ovfSeen           <= 1'b0;
            rx.Rx_ValidFrame  <= 1'b0;
            rx.Rx_EoF         <= 1'b1;
            rx.Rx_AbortSignal <= 1'b0;
            rx.Rx_Overflow    <= isOvf;
            rx.Rx_FrameError  <= !isOvf && isErr;
            if (!isOvf && !isErr) begin
              state           <= HOLD;
              rx.Rx_Ready     <= 1'b1;
              rx.Rx_FrameSize <= rx.Rx_FCSen ? effCount - SIZE_W'(HDLC_FCS_BYTES) : effCount;
            end
          end else begin
            rx.Rx_ValidFrame <= 1'b1;
            if (byteOvf) ovfSeen <= 1'b1;
          end
        end
        HOLD: begin
          if (rx.Rx_ReadDone || rx.Rx_Drop) begin
            state           <= IDLE;
            rx.Rx_Ready     <= 1'b0;
            rx.Rx_FrameSize <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// tb/tb_hdlc_rx_ctrl.sv - directed scoreboard bench for hdlc_rx_ctrl
module tb_hdlc_rx_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  hdlc_rx_ctrl_if #(.SIZE_W(8)) rxIf ();

  hdlc_rx_ctrl #(.MAX_BYTES(128), .MIN_BYTES(3), .SIZE_W(8)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .rx (rxIf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       abort;
    logic       ovf;
    logic       ferr;
    logic       ready;
    logic [7:0] size;
    int         writes;
  } exp_t;

  exp_t expQ[$];
  int   passCnt  = 0;
  int   totalCnt = 0;
  int   eofCnt   = 0;
  int   wrSince  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    totalCnt++;
    assert (obs === expv) passCnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic sendFlag();
    rxIf.Rx_FlagDetect = 1'b1;
    step();
    rxIf.Rx_FlagDetect = 1'b0;
    step();
  endtask

  task automatic sendBytes(input int n);
    repeat (n) begin
      rxIf.Rx_NewByte = 1'b1;
      step();
      rxIf.Rx_NewByte = 1'b0;
      step();
    end
  endtask

  task automatic pushExp(input logic a, input logic o, input logic f, input logic r,
                         input logic [7:0] s, input int w);
    exp_t e;
    e.abort = a; e.ovf = o; e.ferr = f; e.ready = r; e.size = s; e.writes = w;
    expQ.push_back(e);
  endtask

  // End-of-frame monitor: counts write strobes and compares status against the scoreboard.
  always @(negedge Clk) begin
    int   w;
    exp_t e;
    if (!Rst) begin
      wrSince = 0;
    end else begin
      w = wrSince + (rxIf.Rx_WrBuff ? 1 : 0);
      if (rxIf.Rx_EoF) begin
        eofCnt++;
        if (expQ.size() == 0) begin
          check("unexpected_eof", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          check("eof_abort", 32'(rxIf.Rx_AbortSignal), 32'(e.abort));
          check("eof_overflow", 32'(rxIf.Rx_Overflow), 32'(e.ovf));
          check("eof_frameerror", 32'(rxIf.Rx_FrameError), 32'(e.ferr));
          check("eof_ready", 32'(rxIf.Rx_Ready), 32'(e.ready));
          check("eof_framesize", 32'(rxIf.Rx_FrameSize), 32'(e.size));
          check("eof_validframe", 32'(rxIf.Rx_ValidFrame), 32'd0);
          check("eof_writes", 32'(w), 32'(e.writes));
        end
        w = 0;
      end
      wrSince = w;
    end
  end

  task automatic checkAllZero(input string tag);
    check({tag, "_valid"}, 32'(rxIf.Rx_ValidFrame), 32'd0);
    check({tag, "_wrbuff"}, 32'(rxIf.Rx_WrBuff), 32'd0);
    check({tag, "_eof"}, 32'(rxIf.Rx_EoF), 32'd0);
    check({tag, "_abort"}, 32'(rxIf.Rx_AbortSignal), 32'd0);
    check({tag, "_overflow"}, 32'(rxIf.Rx_Overflow), 32'd0);
    check({tag, "_ferr"}, 32'(rxIf.Rx_FrameError), 32'd0);
    check({tag, "_ready"}, 32'(rxIf.Rx_Ready), 32'd0);
    check({tag, "_size"}, 32'(rxIf.Rx_FrameSize), 32'd0);
  endtask

  initial begin
    rxIf.Rx_FlagDetect  = 1'b0;
    rxIf.Rx_AbortDetect = 1'b0;
    rxIf.Rx_NewByte     = 1'b0;
    rxIf.Rx_ByteAligned = 1'b1;
    rxIf.Rx_FCSen       = 1'b1;
    rxIf.Rx_FCSerr      = 1'b0;
    rxIf.Rx_ReadDone    = 1'b0;
    rxIf.Rx_Drop        = 1'b0;
    Rst = 1'b0;
    step(2);
    checkAllZero("reset");
    Rst = 1'b1;
    step();

    // Good frame with FCS: 5 bytes -> size 3
    sendFlag();
    check("open_valid", 32'(rxIf.Rx_ValidFrame), 32'd1);
    sendBytes(5);
    pushExp(1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 5);
    sendFlag();
    check("good_ready", 32'(rxIf.Rx_Ready), 32'd1);
    check("good_size", 32'(rxIf.Rx_FrameSize), 32'd3);

    // HOLD ignores a whole new frame
    sendFlag();
    sendBytes(3);
    sendFlag();
    check("hold_ready", 32'(rxIf.Rx_Ready), 32'd1);
    check("hold_size", 32'(rxIf.Rx_FrameSize), 32'd3);
    rxIf.Rx_ReadDone = 1'b1;
    step();
    rxIf.Rx_ReadDone = 1'b0;
    check("readdone_ready", 32'(rxIf.Rx_Ready), 32'd0);
    check("readdone_size", 32'(rxIf.Rx_FrameSize), 32'd0);
    step();

    // Abort mid-frame
    sendFlag();
    sendBytes(3);
    pushExp(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3);
    rxIf.Rx_AbortDetect = 1'b1;
    step();
    rxIf.Rx_AbortDetect = 1'b0;
    check("abort_eof_latency", 32'(rxIf.Rx_EoF), 32'd1);
    check("abort_signal", 32'(rxIf.Rx_AbortSignal), 32'd1);
    step();
    check("abort_eof_single", 32'(rxIf.Rx_EoF), 32'd0);
    check("abort_idle_valid", 32'(rxIf.Rx_ValidFrame), 32'd0);
    rxIf.Rx_AbortDetect = 1'b1;
    step();
    rxIf.Rx_AbortDetect = 1'b0;
    step();
    check("abort_in_idle_sticky", 32'(rxIf.Rx_AbortSignal), 32'd1);
    sendFlag();
    check("flag_clears_abort", 32'(rxIf.Rx_AbortSignal), 32'd0);
    check("flag_reopens_valid", 32'(rxIf.Rx_ValidFrame), 32'd1);

    // Overflow: 130 bytes, only 128 written
    sendBytes(130);
    pushExp(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 128);
    sendFlag();
    check("ovf_sticky", 32'(rxIf.Rx_Overflow), 32'd1);
    check("ovf_stays_frame", 32'(rxIf.Rx_ValidFrame), 32'd1);

    // Shared flag with no bytes: no end-of-frame
    sendFlag();

    // Frame errors: short, FCS fail, misaligned
    sendBytes(2);
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    sendFlag();
    sendBytes(4);
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4);
    rxIf.Rx_FCSerr = 1'b1;
    sendFlag();
    rxIf.Rx_FCSerr = 1'b0;
    sendBytes(4);
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4);
    rxIf.Rx_ByteAligned = 1'b0;
    sendFlag();
    rxIf.Rx_ByteAligned = 1'b1;
    check("ferr_sticky", 32'(rxIf.Rx_FrameError), 32'd1);

    // Drop in FRAME, then drop in IDLE clears sticky status
    sendBytes(2);
    rxIf.Rx_Drop = 1'b1;
    step();
    rxIf.Rx_Drop = 1'b0;
    check("drop_frame_valid", 32'(rxIf.Rx_ValidFrame), 32'd0);
    rxIf.Rx_Drop = 1'b1;
    step();
    rxIf.Rx_Drop = 1'b0;
    check("drop_idle_clears_ferr", 32'(rxIf.Rx_FrameError), 32'd0);

    // Reset mid-frame, then a clean frame
    sendFlag();
    sendBytes(10);
    Rst = 1'b0;
    step();
    checkAllZero("midreset");
    Rst = 1'b1;
    step();
    sendBytes(2);
    sendFlag();
    sendBytes(4);
    pushExp(1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 4);
    sendFlag();
    check("post_reset_ready", 32'(rxIf.Rx_Ready), 32'd1);
    rxIf.Rx_ReadDone = 1'b1;
    step();
    rxIf.Rx_ReadDone = 1'b0;
    step();

    // No FCS; last byte arrives together with the closing flag
    rxIf.Rx_FCSen = 1'b0;
    sendFlag();
    sendBytes(2);
    pushExp(1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 3);
    rxIf.Rx_NewByte    = 1'b1;
    rxIf.Rx_FlagDetect = 1'b1;
    step();
    rxIf.Rx_NewByte    = 1'b0;
    rxIf.Rx_FlagDetect = 1'b0;
    step();
    check("simul_size", 32'(rxIf.Rx_FrameSize), 32'd3);
    rxIf.Rx_Drop = 1'b1;
    step();
    rxIf.Rx_Drop = 1'b0;
    check("hold_drop_ready", 32'(rxIf.Rx_Ready), 32'd0);

    step(3);
    check("scoreboard_empty", 32'(expQ.size()), 32'd0);
    check("eof_count", 32'(eofCnt), 32'd8);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
